// File: rtl/forward_ctrl_pkg.sv
// Shared types and constants for the EX-stage operand forwarding controller.
//   REG_AW        : register-address width (8 general registers)
//   FWD_*         : select codes understood by the EX forwarding mux
//   hist_entry_t  : one destination-write history slot {v, addr, load}
package forward_ctrl_pkg;

  localparam int unsigned REG_AW = 3;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG     = 2'b00;
  localparam fwd_sel_t FWD_BEFORE1 = 2'b10;
  localparam fwd_sel_t FWD_BEFORE2 = 2'b01;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] addr;
    logic              load;
  } hist_entry_t;

endpackage

// File: rtl/forward_ctrl_compare.sv
// Combinational source-vs-history comparator producing one forwarding select.
//   src_i  : source register address
//   use_i  : source is read and the instruction issues this edge
//   h1_i   : history entry of the instruction in EX (one ahead)
//   h2_i   : history entry of the instruction in MEM (two ahead)
//   sel_c  : forwarding select (never 2'b11)
module forward_ctrl_compare
  import forward_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  input  hist_entry_t       h1_i,
  input  hist_entry_t       h2_i,
  output fwd_sel_t          sel_c
);

  // Load flags only matter to the hazard logic in the top.
  logic unused_load;
  assign unused_load = h1_i.load ^ h2_i.load;

  // Younger result (h1) takes priority over the older one (h2).
  always_comb begin
    sel_c = FWD_REG;
    if (use_i) begin
      if (h1_i.v && (src_i == h1_i.addr)) begin
        sel_c = FWD_BEFORE1;
      end else if (h2_i.v && (src_i == h2_i.addr)) begin
        sel_c = FWD_BEFORE2;
      end
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding/hazard controller: tracks the last two issued destination writes,
// registers EX-stage operand forwarding selects and stalls ID one cycle on a
// load-use hazard.
//   clk, rst_n              : clock, async active-low reset
//   id_valid, id_flush      : ID holds an instruction / kill it
//   id_rs, id_rt            : source addresses; id_use_rs/id_use_rt: read flags
//   id_wr_en, id_wr_addr    : destination write; id_is_load: load instruction
//   fwd_sel_a, fwd_sel_b    : registered forwarding selects for EX
//   stall, issue            : combinational ID hold / advance
module forward_ctrl
  import forward_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  output fwd_sel_t          fwd_sel_a,
  output fwd_sel_t          fwd_sel_b,
  output logic              stall,
  output logic              issue
);

  hist_entry_t h1_q, h1_d;
  hist_entry_t h2_q;
  fwd_sel_t    sel_a_q, sel_b_q;
  fwd_sel_t    sel_a_c, sel_b_c;
  logic        hit_rs_c, hit_rt_c;

  // Load-use hazard against the instruction now in EX; flush suppresses it.
  always_comb begin
    hit_rs_c = id_use_rs && (id_rs == h1_q.addr);
    hit_rt_c = id_use_rt && (id_rt == h1_q.addr);
    stall    = id_valid && !id_flush && h1_q.v && h1_q.load && (hit_rs_c || hit_rt_c);
    issue    = id_valid && !id_flush && !stall;
  end

  // Non-issuing slots (stall, flush, idle) enter the pipe as bubbles.
  always_comb begin
    h1_d = '0;
    if (issue) begin
      h1_d.v    = id_wr_en;
      h1_d.addr = id_wr_addr;
      h1_d.load = id_is_load;
    end
  end

  forward_ctrl_compare u_cmp_a (
    .src_i (id_rs),
    .use_i (issue && id_use_rs),
    .h1_i  (h1_q),
    .h2_i  (h2_q),
    .sel_c (sel_a_c)
  );

  forward_ctrl_compare u_cmp_b (
    .src_i (id_rt),
    .use_i (issue && id_use_rt),
    .h1_i  (h1_q),
    .h2_i  (h2_q),
    .sel_c (sel_b_c)
  );

  // History shift and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q    <= '0;
      h2_q    <= '0;
      sel_a_q <= FWD_REG;
      sel_b_q <= FWD_REG;
    end else begin
      h1_q    <= h1_d;
      h2_q    <= h1_q;
      sel_a_q <= sel_a_c;
      sel_b_q <= sel_b_c;
    end
  end

  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Forwarding/hazard controller for the 16-bit pipelined core; sits upstream of the EX-stage operand forwarding muxes and drives their 2-bit select codes.
- Keeps a 2-deep history of destination-register writes from issued instructions.
- Compares each ID-stage instruction's source registers against that history, and registers the select codes so they arrive in EX with the instruction.
- Detects load-use hazards and stalls ID for exactly one cycle.

Parameters:
- REG_AW, 3, register-address width (8 general registers).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_flush  in  1  kill ID instruction (branch taken); it does not issue.
- id_rs  in  REG_AW  source A register address.
- id_rt  in  REG_AW  source B register address.
- id_use_rs  in  1  source A is read.
- id_use_rt  in  1  source B is read.
- id_wr_en  in  1  instruction writes a register.
- id_wr_addr  in  REG_AW  destination register.
- id_is_load  in  1  instruction is a memory load (result available one stage late).
- fwd_sel_a  out  2  select for operand A mux in EX.
- fwd_sel_b  out  2  select for operand B mux in EX.
- stall  out  1  hold PC/IF/ID this cycle (combinational).
- issue  out  1  ID instruction advances this edge (combinational).

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block uses the single clock clk.
- Select encoding, fixed and shared with the forwarding mux:
  - 2'b00 = register file.
  - 2'b10 = data_before1 (result of the instruction one ahead).
  - 2'b01 = data_before2 (result of the instruction two ahead).
  - 2'b11 is never driven.
- History registers:
  - h1 = {v, addr, load} for the instruction currently in EX.
  - h2 = {v, addr} for the instruction currently in MEM.
- stall = id_valid & !id_flush & h1.v & h1.load & ((id_use_rs & id_rs==h1.addr) | (id_use_rt & id_rt==h1.addr)).
- issue = id_valid & !id_flush & !stall.
- Each rising edge:
  - h2 <= h1.
  - h1 <= issue ? {id_wr_en, id_wr_addr, id_is_load} : bubble (v=0).
- Select generation, registered on each edge, per source X in {rs, rt}:
  - If !issue or !id_use_X: sel <= 00.
  - Else if h1.v & id_X==h1.addr: sel <= 10. Younger result wins; a load here is impossible because stall would be active.
  - Else if h2.v & id_X==h2.addr: sel <= 01.
  - Else: sel <= 00.
- Latency: select valid in the cycle after issue, aligned with the instruction in EX.
- Load-use sequence:
  - Cycle N: stall=1, bubble enters h1, sels for the bubble = 00.
  - Cycle N+1: the load is now in h2; the same instruction issues with sel=01.
- Stall never lasts more than one consecutive cycle for the same instruction: after the bubble, h1.v=0.
- id_flush has priority over stall: a flushed instruction issues as a bubble and raises no stall.
- Both sources matching the same history entry: both sels are set identically.
- rs==rt is allowed.
- Register 0 is an ordinary register and is forwarded like any other.
- Reset: h1.v=h2.v=0, all addr/load fields 0, fwd_sel_a=fwd_sel_b=00. stall and issue follow from the reset state (stall=0).
- Reset asserted mid-stall clears the history immediately; no stall is pending after release.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_BEFORE1=2'b10, FWD_BEFORE2=2'b01.
  - REG_AW.
  - The hist_entry struct {v, addr, load}.
- One natural sub-module: fwd_compare. It is combinational; its inputs are src addr, use, h1 and h2, and its output is the 2-bit select. It is instantiated twice, for A and B.
- Hazard detection and history registers stay in the top.

Test Plan:
- No dependency: issue r1<-r2+r3, then r4<-r5+r6 -> both sels 00, stall never 1.
- Back-to-back ALU dependency: r1<-..., next reads r1 as rs -> fwd_sel_a=10 in the second instruction's EX cycle; fwd_sel_b=00.
- Distance-2 dependency with priority:
  - r1<-..., r2<-..., read r1 -> sel 01.
  - r1<-..., r1<-..., read r1 -> sel 10 (younger wins).
- Load-use: load r3, next reads r3 as rt -> stall=1 for exactly one cycle, issue=0, bubble sels 00; next cycle fwd_sel_b=01.
- Flush and bubbles:
  - Flush an instruction that would stall -> stall=0.
  - A later reader of the flushed instruction's destination gets sel 00.
  - id_valid=0 gaps age entries; a dependency spanning 2 gaps -> 00.
- Reset mid-operation: assert rst_n=0 asynchronously while stall=1 -> sels 00 and stall 0 immediately; first post-reset instruction reading any register gets 00.
